// File: rtl/vai_wrr_tx_mux_if.sv
// Shared CCI-P Tx types and the bundle interface for vai_wrr_tx_mux.
// vai_ccip_pkg: trimmed CCI-P Tx channel structs (c0 read, c1 write, c2 MMIO rsp).
// vai_wrr_tx_mux_if: per-AFU Tx ports, per-AFU weights and almFull, merged upstream port.
//   master : sub-AFU / upstream side (drives requests, weights, upstream almFull)
//   slave  : the mux side
package vai_ccip_pkg;
  typedef struct packed { logic [15:0] addr; } t_c0_hdr;
  typedef struct packed { logic sop; logic [1:0] cl_len; logic [15:0] addr; } t_c1_hdr;
  typedef struct packed { logic [8:0] tid; } t_c2_hdr;
  typedef struct packed { t_c0_hdr hdr; logic valid; } t_c0_tx;
  typedef struct packed { t_c1_hdr hdr; logic [31:0] data; logic valid; } t_c1_tx;
  typedef struct packed { t_c2_hdr hdr; logic [31:0] data; logic valid; } t_c2_tx;
  typedef struct packed { t_c0_tx c0; t_c1_tx c1; t_c2_tx c2; } t_if_ccip_Tx;
  typedef struct packed { t_c1_hdr hdr; logic [31:0] data; } t_c1_ent;
endpackage

interface vai_wrr_tx_mux_if #(
  parameter int NUM_SUB_AFUS = 8,
  parameter int WEIGHT_W     = 4
);
  import vai_ccip_pkg::*;
  logic        [NUM_SUB_AFUS-1:0][WEIGHT_W-1:0] weight;
  t_if_ccip_Tx [NUM_SUB_AFUS-1:0]               afu_TxPort;
  logic        [NUM_SUB_AFUS-1:0]               afu_c0_almFull;
  logic        [NUM_SUB_AFUS-1:0]               afu_c1_almFull;
  t_if_ccip_Tx                                  up_TxPort;
  logic                                         up_c0TxAlmFull;
  logic                                         up_c1TxAlmFull;

  modport master (output weight, afu_TxPort, up_c0TxAlmFull, up_c1TxAlmFull,
                  input  afu_c0_almFull, afu_c1_almFull, up_TxPort);
  modport slave  (input  weight, afu_TxPort, up_c0TxAlmFull, up_c1TxAlmFull,
                  output afu_c0_almFull, afu_c1_almFull, up_TxPort);
endinterface

// File: rtl/vai_wrr_tx_mux.sv
// Weighted-round-robin CCI-P Tx mux: per-AFU c0/c1 FIFOs, one WRR arbiter per
// channel (c1 locks on multi-line writes), fixed-priority unbuffered c2.
// Ports: pClk (clock), SoftReset (sync, active high), tx (vai_wrr_tx_mux_if.slave).

// Per-AFU, per-channel request FIFO with registered occupancy.
module vai_wrr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int SLACK = 8
) (
  input  logic         pClk,
  input  logic         SoftReset,
  input  logic         wrEn,
  input  logic [W-1:0] wrData,
  input  logic         rdEn,
  output logic [W-1:0] rdData,
  output logic         notEmpty,
  output logic         lastOut,   // a pop now leaves the FIFO empty
  output logic         almFull
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wPtr, rPtr;
  logic [AW:0]   cnt;
  logic          push, pop;

  assign push     = wrEn & (cnt != (AW+1)'(DEPTH));   // write into full is dropped
  assign pop      = rdEn & notEmpty;
  assign notEmpty = (cnt != '0);
  assign lastOut  = (cnt == (AW+1)'(1)) & ~push;
  assign almFull  = (cnt >= (AW+1)'(DEPTH - SLACK)) | SoftReset;
  assign rdData   = mem[rPtr];

  always_ff @(posedge pClk) if (push) mem[wPtr] <= wrData;

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      wPtr <= '0;
      rPtr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wPtr <= wPtr + 1'b1;
      if (pop)  rPtr <= rPtr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// One-channel WRR arbiter. LOCK_EN holds ptr across multi-line c1 packets.
module vai_wrr_arb #(
  parameter int N        = 8,
  parameter int WEIGHT_W = 4,
  parameter bit LOCK_EN  = 1'b0
) (
  input  logic                        pClk,
  input  logic                        SoftReset,
  input  logic [N-1:0][WEIGHT_W-1:0]  weight,
  input  logic [N-1:0]                notEmpty,
  input  logic [N-1:0]                lastOut,
  input  logic [N-1:0]                headSop,
  input  logic [N-1:0][1:0]           headLen,
  input  logic                        upAlmFull,
  output logic                        gnt,
  output logic [$clog2(N)-1:0]        gntIdx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0]       ptr, sel, jIdx, nIdx;
  logic [WEIGHT_W-1:0] q, qBase, qNext, wm1;
  logic [1:0]          beats;
  logic                lock, cand, jFound, nFound, startLock, lastBeat, rotate;
  logic [N-1:0]        elig, eligAfter;

  // Circular search for the first set bit starting at 'start'; returns {found, idx}.
  function automatic logic [IW:0] findNext(input logic [N-1:0] v, input logic [IW-1:0] start);
    logic          found;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = start;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && v[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) elig[i] = notEmpty[i] & (weight[i] != '0);
    {jFound, jIdx} = findNext(elig, IW'((int'(ptr) + 1) % N));
    if (lock) begin
      cand = notEmpty[ptr];
      sel  = ptr;
    end else if (elig[ptr]) begin
      cand = 1'b1;
      sel  = ptr;
    end else begin
      cand = jFound;
      sel  = jIdx;
    end
    gnt    = cand & ~upAlmFull;
    gntIdx = sel;
    // a jump to a new AFU starts its quota from zero
    qBase     = (sel == ptr) ? q : '0;
    wm1       = weight[sel] - 1'b1;
    qNext     = (qBase >= wm1) ? wm1 : qBase + 1'b1;
    startLock = LOCK_EN && !lock && headSop[sel] && (headLen[sel] != 2'd0);
    lastBeat  = lock && (beats == 2'd1);
    // mid-packet beats never rotate; the closing beat re-evaluates quota
    rotate    = !startLock && (!lock || lastBeat) && ((qBase >= wm1) || lastOut[sel]);
    eligAfter      = elig;
    eligAfter[sel] = elig[sel] & ~lastOut[sel];
    {nFound, nIdx} = findNext(eligAfter, IW'((int'(sel) + 1) % N));
  end

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      ptr   <= '0;
      q     <= '0;
      lock  <= 1'b0;
      beats <= '0;
    end else if (gnt) begin
      if (startLock) begin
        lock  <= 1'b1;
        beats <= headLen[sel];
      end else if (lock) begin
        beats <= beats - 1'b1;
        if (lastBeat) lock <= 1'b0;
      end
      ptr <= (rotate && nFound) ? nIdx : sel;
      q   <= rotate ? '0 : qNext;
    end
  end
endmodule

module vai_wrr_tx_mux
  import vai_ccip_pkg::*;
#(
  parameter int NUM_SUB_AFUS  = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int ALMFULL_SLACK = 8,
  parameter int WEIGHT_W      = 4
) (
  input logic              pClk,
  input logic              SoftReset,
  vai_wrr_tx_mux_if.slave  tx
);
  localparam int N  = NUM_SUB_AFUS;
  localparam int IW = $clog2(N);

  t_c0_hdr [N-1:0]       c0Head;
  t_c1_ent [N-1:0]       c1Head;
  logic    [N-1:0]       c0NotEmpty, c1NotEmpty, c0Last, c1Last, c0Pop, c1Pop;
  logic    [N-1:0]       c0AlmFull, c1AlmFull, c1Sop;
  logic    [N-1:0][1:0]  c1Len;
  logic                  c0Gnt, c1Gnt;
  logic    [IW-1:0]      c0Idx, c1Idx;
  t_c2_tx                c2Sel;
  t_if_ccip_Tx           upReg, upOut;

  for (genvar i = 0; i < N; i++) begin : g_afu
    vai_wrr_fifo #(.W($bits(t_c0_hdr)), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK)) u_c0 (
      .pClk(pClk), .SoftReset(SoftReset),
      .wrEn(tx.afu_TxPort[i].c0.valid), .wrData(tx.afu_TxPort[i].c0.hdr),
      .rdEn(c0Pop[i]), .rdData(c0Head[i]), .notEmpty(c0NotEmpty[i]),
      .lastOut(c0Last[i]), .almFull(c0AlmFull[i]));
    vai_wrr_fifo #(.W($bits(t_c1_ent)), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK)) u_c1 (
      .pClk(pClk), .SoftReset(SoftReset),
      .wrEn(tx.afu_TxPort[i].c1.valid),
      .wrData({tx.afu_TxPort[i].c1.hdr, tx.afu_TxPort[i].c1.data}),
      .rdEn(c1Pop[i]), .rdData(c1Head[i]), .notEmpty(c1NotEmpty[i]),
      .lastOut(c1Last[i]), .almFull(c1AlmFull[i]));
    assign c0Pop[i] = c0Gnt & (c0Idx == IW'(i));
    assign c1Pop[i] = c1Gnt & (c1Idx == IW'(i));
    assign c1Sop[i] = c1Head[i].hdr.sop;
    assign c1Len[i] = c1Head[i].hdr.cl_len;
  end

  assign tx.afu_c0_almFull = c0AlmFull;
  assign tx.afu_c1_almFull = c1AlmFull;

  vai_wrr_arb #(.N(N), .WEIGHT_W(WEIGHT_W), .LOCK_EN(1'b0)) u_arbC0 (
    .pClk(pClk), .SoftReset(SoftReset), .weight(tx.weight),
    .notEmpty(c0NotEmpty), .lastOut(c0Last), .headSop('0), .headLen('0),
    .upAlmFull(tx.up_c0TxAlmFull), .gnt(c0Gnt), .gntIdx(c0Idx));

  vai_wrr_arb #(.N(N), .WEIGHT_W(WEIGHT_W), .LOCK_EN(1'b1)) u_arbC1 (
    .pClk(pClk), .SoftReset(SoftReset), .weight(tx.weight),
    .notEmpty(c1NotEmpty), .lastOut(c1Last), .headSop(c1Sop), .headLen(c1Len),
    .upAlmFull(tx.up_c1TxAlmFull), .gnt(c1Gnt), .gntIdx(c1Idx));

  // c2: lowest index wins, others are dropped
  always_comb begin
    c2Sel = '0;
    for (int i = N-1; i >= 0; i--)
      if (tx.afu_TxPort[i].c2.valid) c2Sel = tx.afu_TxPort[i].c2;
  end

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      upReg.c0.valid <= 1'b0;
      upReg.c1.valid <= 1'b0;
      upReg.c2.valid <= 1'b0;
    end else begin
      upReg.c0.valid <= c0Gnt;
      upReg.c1.valid <= c1Gnt;
      upReg.c2.valid <= c2Sel.valid;
    end
    upReg.c0.hdr  <= c0Head[c0Idx];
    upReg.c1.hdr  <= c1Head[c1Idx].hdr;
    upReg.c1.data <= c1Head[c1Idx].data;
    upReg.c2.hdr  <= c2Sel.hdr;
    upReg.c2.data <= c2Sel.data;
  end

  // valids are also masked during the reset cycle itself, not only after it
  always_comb begin
    upOut          = upReg;
    upOut.c0.valid = upReg.c0.valid & ~SoftReset;
    upOut.c1.valid = upReg.c1.valid & ~SoftReset;
    upOut.c2.valid = upReg.c2.valid & ~SoftReset;
  end
  assign tx.up_TxPort = upOut;
endmodule

// File: doc/vai_wrr_tx_mux.md
# vai_wrr_tx_mux

Parametrised weighted-round-robin CCI-P Tx multiplexer for the VAI shim. It merges the Tx ports of NUM_SUB_AFUS sub-AFUs into one upstream Tx port and buffers each sub-AFU's c0 and c1 traffic in its own FIFO. Each sub-AFU sees a private almost-full back-pressure signal. c0 and c1 are arbitrated independently with runtime-programmable per-AFU weights, and multi-line c1 writes are never interleaved. It replaces the fixed round-robin tx_mux between the audit stage and the upstream port.

## Interface
- NUM_SUB_AFUS, 8: number of sub-AFU ports; legal range 2..16.
- FIFO_DEPTH, 16: entries per AFU per channel; power of two, ≥ ALMFULL_SLACK+4.
- ALMFULL_SLACK, 8: requests an AFU may still issue after its almFull asserts.
- WEIGHT_W, 4: width of each weight field.

- pClk  in  1  sole clock; all logic on its rising edge.
- SoftReset  in  1  synchronous, active-high reset.
- weight  in  [NUM_SUB_AFUS-1:0][WEIGHT_W-1:0]  per-AFU grant quota; 0 masks the AFU.
- afu_TxPort  in  t_if_ccip_Tx [NUM_SUB_AFUS-1:0]  sub-AFU requests; c0, c1, c2 used.
- afu_c0_almFull  out  1 [NUM_SUB_AFUS-1:0]  per-AFU c0 back-pressure.
- afu_c1_almFull  out  1 [NUM_SUB_AFUS-1:0]  per-AFU c1 back-pressure.
- up_TxPort  out  t_if_ccip_Tx  merged upstream request port; registered.
- up_c0TxAlmFull  in  1  upstream c0 back-pressure.
- up_c1TxAlmFull  in  1  upstream c1 back-pressure.

## Operation
- Enqueue:
  - Per AFU, per channel: a FIFO of FIFO_DEPTH entries holding {hdr, data}.
  - A valid request is written on the same edge.
  - A write to a full FIFO is dropped. This is a protocol violation; the bench flags it.
- almFull:
  - afu_cX_almFull[i] = (occupancy ≥ FIFO_DEPTH − ALMFULL_SLACK) | SoftReset.
  - Computed from registered occupancy.
- Arbiter, one per channel:
  - State: ptr (current AFU), quota counter q, lock flag, beat counter.
  - Eligible AFU: FIFO non-empty and weight ≠ 0.
  - A grant is issued only when upstream almFull for that channel is low.
  - On a grant to ptr: q++.
  - Rotation: if q == weight[ptr] − 1, or ptr's FIFO becomes empty after the pop, ptr moves to the next eligible AFU (circular search from ptr+1) and q clears.
  - If ptr is not eligible, the arbiter jumps to the next eligible AFU in the same cycle and grants it.
  - The search wraps NUM_SUB_AFUS−1 → 0.
- c1 multi-line lock:
  - Grant of an entry with sop=1 and cl_len≠0 sets lock and beat counter = cl_len.
  - While locked, only ptr is granted.
  - Quota and emptiness do not rotate ptr while locked.
  - The counter decrements per granted beat; lock clears after the last beat.
  - Quota overrun from a packet is allowed; q saturates at weight−1.
- c2 (MMIO read response):
  - Unbuffered, fixed priority, lowest index wins.
  - Registered to up_TxPort.c2.
  - Losers are lost; by construction only one AFU responds at a time.
- Weight changes take effect at the next rotation decision. A weight changed to 0 mid-quota forces rotation on the next grant opportunity, unless locked.
- All masked or all empty: no grant, up valid=0, ptr holds.
- Simultaneous enqueue and dequeue on the same FIFO: occupancy unchanged. Enqueue into an empty FIFO is not bypassed.
- Reset mid-operation:
  - All FIFOs flush and all arbiter state clears (ptr=0, q=0, lock=0).
  - Entries in flight are discarded.

## Timing
- Reset values:
  - up_TxPort c0/c1/c2 valid = 0; header/data don't-care.
  - afu_c*_almFull = 1 while SoftReset is high.
  - afu_c*_almFull = 0 on the first cycle after release.
- Latency:
  - Request valid at cycle t into an empty FIFO is granted at t+1.
  - The request appears on up_TxPort at t+2.
  - c2 latency is 1 cycle.
- Throughput: one grant per channel per cycle; c0 and c1 grant in the same cycle independently.
- Back-pressure:
  - up almFull sampled at cycle t blocks a grant at t.
  - The output register already loaded still presents at t+1; CCI-P slack absorbs it.
- almFull rises the cycle after occupancy crosses the threshold.

## Test plan
- Single-AFU stream:
  - Stimulus: weights all 1, AFU 3 issues 4 c0 reads at t=0..3, upstream never full.
  - Required: up c0 valid at t=2..5, headers in order, AFU 3 almFull stays 0.
- Weighted share:
  - Stimulus: weights {AFU0=3, AFU1=1}, both FIFOs kept non-empty on c1 (single-line writes), 40 grants.
  - Required: output pattern 0,0,0,1 repeating, 30:10 split.
- Multi-line lock:
  - Stimulus: AFU0 sends a cl_len=3 (4-line) write, AFU1 sends single-line writes, weights all 1.
  - Required: 4 AFU0 beats contiguous, then AFU1; no interleave.
- Back-pressure and almFull:
  - Stimulus: FIFO_DEPTH=16, ALMFULL_SLACK=8, up_c0TxAlmFull held 1, AFU2 issues 8 reads.
  - Required: afu_c0_almFull[2] rises the cycle after the 8th write, no up valid.
  - Release: after up_c0TxAlmFull drops, 8 reads emerge consecutively.
- Mask and reset:
  - Stimulus: weight[1]=0 with AFU1 FIFO non-empty.
  - Required: AFU1 is never granted.
  - Then assert SoftReset for 1 cycle mid-stream: all valids 0 and almFull=1 that cycle; FIFOs empty after; ptr restarts at AFU0.
- c2 collision:
  - Stimulus: AFU4 and AFU6 assert c2 valid in the same cycle.
  - Required: AFU4's response is forwarded 1 cycle later; AFU6's is dropped.
